// File: rtl/cga_alu_pkg.sv
// Shared types and constants for the CGA ALU serial datapath blocks.
package cga_alu_pkg;

    localparam int unsigned WIDTH_DFLT = 16;
    localparam int unsigned CNT_W_DFLT = 5;
    localparam int unsigned LEN_W      = 4;
    localparam int unsigned LENX_W     = LEN_W + 1;

    // PARITY keeps its encoding even in builds without the parity option.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // LEN field: 1..15 literal, 0 encodes a full 16-bit word.
    function automatic logic [LENX_W-1:0] len_decode(input logic [LEN_W-1:0] len);
        return (len == '0) ? LENX_W'(WIDTH_DFLT) : {1'b0, len};
    endfunction

endpackage

// File: rtl/cga_alu_bitcnt.sv
// Loadable down-counter with terminal-count flag; decrements only when dec is high.
module cga_alu_bitcnt #(
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign tc = (count == CNT_W'(1));

endmodule

// File: rtl/cga_alu_gpr_serout.sv
// MSB-first parallel-to-serial transmitter feeding the GPR left-shift input.
// Optional trailing even-parity bit when CGA_ALU_GPR_SEROUT_PARITY_EN is defined.
module cga_alu_gpr_serout
    import cga_alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DFLT,
    parameter int unsigned CNT_W = CNT_W_DFLT
) (
    input  logic             ALUCLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_15_0,
    input  logic [LEN_W-1:0] LEN_3_0,
    input  logic             LOAD,
    input  logic             HOLD,
    output logic             READY,
    output logic             SOUT,
    output logic             SHIFTEN,
    output logic             DONE,
    output logic             BUSY
);

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   shreg;
    logic [CNT_W-1:0]   len_eff;
    logic [CNT_W-1:0]   shamt;
    logic [CNT_W-1:0]   cnt;
    logic               cnt_tc;
    logic               load_acc;
    logic               shift_step;

`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
    logic               par_q;
`endif

    assign len_eff = CNT_W'(len_decode(LEN_3_0));
    assign shamt   = CNT_W'(WIDTH) - len_eff;

    cga_alu_bitcnt #(
        .CNT_W    (CNT_W)
    ) u_bitcnt (
        .clk      (ALUCLK),
        .rst      (RESET),
        .load     (load_acc),
        .load_val (len_eff),
        .dec      (shift_step),
        .count    (cnt),
        .tc       (cnt_tc)
    );

    always_ff @(posedge ALUCLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Left-justify the LEN-bit field so DATA[LEN-1] is the first bit out.
    always_ff @(posedge ALUCLK) begin
        if (RESET) begin
            shreg <= '0;
        end else if (load_acc) begin
            shreg <= DATA_15_0 << shamt;
        end else if (shift_step) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
        end
    end

`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
    always_ff @(posedge ALUCLK) begin
        if (RESET) begin
            par_q <= 1'b0;
        end else if (load_acc) begin
            par_q <= 1'b0;
        end else if (shift_step) begin
            par_q <= par_q ^ shreg[WIDTH-1];
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        load_acc   = 1'b0;
        shift_step = 1'b0;
        READY      = 1'b0;
        SOUT       = 1'b0;
        SHIFTEN    = 1'b0;
        DONE       = 1'b0;
        BUSY       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                READY = 1'b1;
                if (LOAD) begin
                    load_acc = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                SOUT       = shreg[WIDTH-1];
                SHIFTEN    = !HOLD;
                BUSY       = 1'b1;
                shift_step = !HOLD && (cnt != '0);
                if (shift_step && cnt_tc) begin
`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_DONE;
`endif
                end
            end
`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
            ST_PARITY: begin
                SOUT    = par_q;
                SHIFTEN = !HOLD;
                BUSY    = 1'b1;
                if (!HOLD) begin
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                DONE    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cga_alu_gpr_serout.sv
// Directed bench for cga_alu_gpr_serout with a GPR shift-left receiver model.
module tb_cga_alu_gpr_serout;

    logic        clk;
    logic        rst;
    logic [15:0] data;
    logic [3:0]  len;
    logic        load;
    logic        hold;
    logic        ready;
    logic        sout;
    logic        shiften;
    logic        done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    cga_alu_gpr_serout dut (
        .ALUCLK    (clk),
        .RESET     (rst),
        .DATA_15_0 (data),
        .LEN_3_0   (len),
        .LOAD      (load),
        .HOLD      (hold),
        .READY     (ready),
        .SOUT      (sout),
        .SHIFTEN   (shiften),
        .DONE      (done),
        .BUSY      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transfer; cycle 1 is the LOAD cycle. Receiver shifts in SOUT on every SHIFTEN.
    // Shift cycles hs..he are held; at cycle ld2 a stray LOAD with new DATA/LEN is driven.
    task automatic xfer(input logic [15:0] d, input logic [3:0] l,
                        input int hs, input int he, input int ld2,
                        output logic [31:0] bits, output int nsh, output int dc);
        logic prev;
        bits = '0;
        nsh  = 0;
        dc   = 0;
        prev = 1'b0;
        @(posedge clk); #1;
        data = d; len = l; load = 1'b1; hold = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c > 1) begin
                if (shiften) begin
                    bits = {bits[30:0], sout};
                    nsh++;
                end
                if (hold) begin
                    check("hold_shiften", 32'(shiften), 32'd0);
                    check("hold_sout", 32'(sout), 32'(prev));
                end
                check("xfer_ready", 32'(ready), 32'd0);
                if (done) begin
                    dc = c;
                    check("done_busy", 32'(busy), 32'd0);
                    check("done_shiften", 32'(shiften), 32'd0);
                    check("done_sout", 32'(sout), 32'd0);
                    break;
                end
                check("xfer_busy", 32'(busy), 32'd1);
            end
            prev = sout;
            @(posedge clk); #1;
            load = (c + 1 == ld2);
            if (c + 1 == ld2) begin
                data = 16'h1234;
                len  = 4'd5;
            end
            hold = (c >= hs) && (c <= he);
        end
        if (dc == 0) check("done_timeout", 32'd0, 32'd1);
        load = 1'b0;
        hold = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("ready_after", 32'(ready), 32'd1);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    logic [31:0] bits;
    int          nsh;
    int          dc;
    logic        seen_done;

    initial begin
        rst = 1'b1; data = '0; len = '0; load = 1'b0; hold = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_sout", 32'(sout), 32'd0);
        check("rst_shiften", 32'(shiften), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full 16-bit word
        xfer(16'hA5C3, 4'd0, 0, -1, -1, bits, nsh, dc);
        check("full_bits", bits, (PB != 0) ? 32'h14B86 : 32'hA5C3);
        check("full_nsh", 32'(nsh), 32'(16 + PB));
        check("full_done_cyc", 32'(dc), 32'(18 + PB));

        // Short length: only the low 4 bits leave the block
        xfer(16'hFFF6, 4'd4, 0, -1, -1, bits, nsh, dc);
        check("short_bits", bits, (PB != 0) ? 32'h0000C : 32'h0006);
        check("short_nsh", 32'(nsh), 32'(4 + PB));
        check("short_done_cyc", 32'(dc), 32'(6 + PB));

        // HOLD on shift cycles 3..5
        xfer(16'h8001, 4'd0, 3, 5, -1, bits, nsh, dc);
        check("hold_bits", bits, (PB != 0) ? 32'h10002 : 32'h8001);
        check("hold_nsh", 32'(nsh), 32'(16 + PB));
        check("hold_done_cyc", 32'(dc), 32'(21 + PB));

        // Stray LOAD (and LEN change) during a transfer is ignored
        xfer(16'h00FF, 4'd0, 0, -1, 6, bits, nsh, dc);
        check("busy_bits", bits, (PB != 0) ? 32'h001FE : 32'h00FF);
        check("busy_nsh", 32'(nsh), 32'(16 + PB));
        check("busy_done_cyc", 32'(dc), 32'(18 + PB));

        // Next LOAD after the idle return is accepted
        xfer(16'h1234, 4'd0, 0, -1, -1, bits, nsh, dc);
        check("next_bits", bits, (PB != 0) ? 32'h02469 : 32'h1234);
        check("next_nsh", 32'(nsh), 32'(16 + PB));

        // RESET at shift cycle 7 aborts with no DONE
        @(posedge clk); #1;
        data = 16'hFFFF; len = 4'd0; load = 1'b1;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_sout", 32'(sout), 32'd0);
        check("abort_shiften", 32'(shiften), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        seen_done = done;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            seen_done = seen_done | done;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        // RESET together with LOAD: LOAD is not accepted
        @(posedge clk); #1;
        rst = 1'b1; load = 1'b1; data = 16'hFFFF;
        @(posedge clk); #1;
        rst = 1'b0; load = 1'b0;
        @(negedge clk);
        check("rstload_ready", 32'(ready), 32'd1);
        check("rstload_busy", 32'(busy), 32'd0);

`ifdef CGA_ALU_GPR_SEROUT_PARITY_EN
        // Parity bit follows the data bits
        xfer(16'h0007, 4'd3, 0, -1, -1, bits, nsh, dc);
        check("par1_bits", bits, 32'hF);
        check("par1_nsh", 32'(nsh), 32'd4);
        check("par1_done_cyc", 32'(dc), 32'd6);
        xfer(16'h0003, 4'd2, 0, -1, -1, bits, nsh, dc);
        check("par0_bits", bits, 32'h6);
        check("par0_nsh", 32'(nsh), 32'd3);
        check("par0_done_cyc", 32'(dc), 32'd5);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
